// File: rtl/rx_dequeue_if.sv
// User-side packet read interface of the RX dequeue path.
// master = rx_dequeue (produces words), slave = packet consumer.
interface rx_dequeue_if;
    logic        pkt_rx_ren;
    logic        pkt_rx_avail;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic        pkt_rx_err;
    logic [2:0]  pkt_rx_mod;

    modport master (
        input  pkt_rx_ren,
        output pkt_rx_avail, pkt_rx_val, pkt_rx_data,
        output pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod
    );

    modport slave (
        output pkt_rx_ren,
        input  pkt_rx_avail, pkt_rx_val, pkt_rx_data,
        input  pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod
    );
endinterface

// File: rtl/rx_dequeue.sv
// RX FIFO read-side controller: pops show-ahead entries and frames whole packets.
// Optional RX_DEQUEUE_STATS_EN adds good/errored packet and dropped-word counters.
//
// state   | meaning
// IDLE    | waiting for a committed packet at the FIFO head
// READ    | forwarding words of the current packet to the user
// DROP    | silently discarding words until the next SOP or an EOP
module rx_dequeue #(
    parameter int PKT_CNT_W = 4,
    parameter int MAX_WORDS = 1200,
    parameter int WCNT_W    = 11
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic [63:0] rxdfifo_rdata,
    input  logic [7:0]  rxdfifo_rstatus,
    input  logic        rxdfifo_rempty,
    output logic        rxdfifo_ren,
    input  logic        rx_pkt_commit,
    rx_dequeue_if.master pkt_rx
`ifdef RX_DEQUEUE_STATS_EN
    ,
    output logic [31:0] stat_rx_pkts,
    output logic [31:0] stat_rx_err_pkts,
    output logic [31:0] stat_rx_drop_words
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [PKT_CNT_W-1:0] PCNT_MAX = '1;
    localparam logic [WCNT_W-1:0]    WCNT_LIM = WCNT_W'(MAX_WORDS);

    logic [1:0]           state, state_nxt;
    logic [PKT_CNT_W-1:0] pcnt;
    logic [WCNT_W-1:0]    wcnt, wcnt_inc;
    logic                 term_pend, term_pend_nxt;
    logic                 pop, emit_word, emit_term;
    logic                 head_sop, head_eop, head_err, pcnt_nz, eop_pop;
    logic                 avail_q, val_q, sop_q, eop_q, err_q;
    logic [63:0]          data_q;
    logic [2:0]           mod_q;
    logic                 status_unused;

    assign head_sop      = rxdfifo_rstatus[7];
    assign head_eop      = rxdfifo_rstatus[6];
    assign head_err      = rxdfifo_rstatus[5];
    assign status_unused = ^rxdfifo_rstatus[4:3];
    assign pcnt_nz       = (pcnt != '0);
    assign wcnt_inc      = wcnt + 1'b1;
    assign eop_pop       = pop && head_eop;

    // Over-length terminator is emitted from DROP one cycle after the last allowed word.
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        emit_word     = 1'b0;
        emit_term     = term_pend;
        term_pend_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (avail_q && pcnt_nz && !rxdfifo_rempty) begin
                    if (!head_sop) begin
                        state_nxt = ST_DROP;
                    end else if (pkt_rx.pkt_rx_ren) begin
                        pop       = 1'b1;
                        emit_word = 1'b1;
                        state_nxt = head_eop ? ST_IDLE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (pkt_rx.pkt_rx_ren && !rxdfifo_rempty) begin
                    if (head_sop) begin
                        emit_term = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        pop       = 1'b1;
                        emit_word = 1'b1;
                        if (head_eop) begin
                            state_nxt = ST_IDLE;
                        end else if (wcnt_inc == WCNT_LIM) begin
                            state_nxt     = ST_DROP;
                            term_pend_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (!rxdfifo_rempty) begin
                    if (head_sop) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        pop = 1'b1;
                        if (head_eop) state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rxdfifo_ren = pop;

    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state     <= ST_IDLE;
            term_pend <= 1'b0;
            pcnt      <= '0;
            wcnt      <= '0;
            avail_q   <= 1'b0;
            val_q     <= 1'b0;
            data_q    <= '0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            mod_q     <= '0;
        end else begin
            state     <= state_nxt;
            term_pend <= term_pend_nxt;
            avail_q   <= (state == ST_IDLE) && pcnt_nz;
            if (rx_pkt_commit && !eop_pop && (pcnt != PCNT_MAX)) begin
                pcnt <= pcnt + 1'b1;
            end else if (!rx_pkt_commit && eop_pop && pcnt_nz) begin
                pcnt <= pcnt - 1'b1;
            end
            if (pop && (state == ST_IDLE)) begin
                wcnt <= WCNT_W'(1);
            end else if (pop && (state == ST_READ)) begin
                wcnt <= wcnt_inc;
            end
            val_q <= emit_word || emit_term;
            if (emit_term) begin
                data_q <= '0;
                sop_q  <= 1'b0;
                eop_q  <= 1'b1;
                err_q  <= 1'b1;
                mod_q  <= '0;
            end else if (emit_word) begin
                data_q <= rxdfifo_rdata;
                sop_q  <= (state == ST_IDLE);
                eop_q  <= head_eop;
                err_q  <= head_err;
                mod_q  <= head_eop ? rxdfifo_rstatus[2:0] : 3'd0;
            end
        end
    end

    assign pkt_rx.pkt_rx_avail = avail_q;
    assign pkt_rx.pkt_rx_val   = val_q;
    assign pkt_rx.pkt_rx_data  = data_q;
    assign pkt_rx.pkt_rx_sop   = sop_q;
    assign pkt_rx.pkt_rx_eop   = eop_q;
    assign pkt_rx.pkt_rx_err   = err_q;
    assign pkt_rx.pkt_rx_mod   = mod_q;

`ifdef RX_DEQUEUE_STATS_EN
    // Counted on the edge that registers the corresponding output word.
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            stat_rx_pkts       <= '0;
            stat_rx_err_pkts   <= '0;
            stat_rx_drop_words <= '0;
        end else begin
            if (!emit_term && emit_word && head_eop && !head_err) begin
                stat_rx_pkts <= stat_rx_pkts + 1'b1;
            end
            if (emit_term || (emit_word && head_eop && head_err)) begin
                stat_rx_err_pkts <= stat_rx_err_pkts + 1'b1;
            end
            if (pop && (state == ST_DROP)) begin
                stat_rx_drop_words <= stat_rx_drop_words + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_dequeue.sv
// Randomized bench for rx_dequeue: a FIFO model feeds packet streams and the
// expected output word list is derived from the framing rules at stream level.
module tb_rx_dequeue;
    localparam int MAXW = 4;

    logic        clk_156m25      = 1'b0;
    logic        reset_156m25_n  = 1'b0;
    logic [63:0] rxdfifo_rdata   = '0;
    logic [7:0]  rxdfifo_rstatus = '0;
    logic        rxdfifo_rempty  = 1'b1;
    logic        rxdfifo_ren;
    logic        rx_pkt_commit   = 1'b0;
    rx_dequeue_if pkt_rx();
`ifdef RX_DEQUEUE_STATS_EN
    logic [31:0] stat_rx_pkts, stat_rx_err_pkts, stat_rx_drop_words;
`endif

    rx_dequeue #(.PKT_CNT_W(4), .MAX_WORDS(MAXW), .WCNT_W(11)) dut (
        .clk_156m25      (clk_156m25),
        .reset_156m25_n  (reset_156m25_n),
        .rxdfifo_rdata   (rxdfifo_rdata),
        .rxdfifo_rstatus (rxdfifo_rstatus),
        .rxdfifo_rempty  (rxdfifo_rempty),
        .rxdfifo_ren     (rxdfifo_ren),
        .rx_pkt_commit   (rx_pkt_commit),
        .pkt_rx          (pkt_rx.master)
`ifdef RX_DEQUEUE_STATS_EN
        ,
        .stat_rx_pkts       (stat_rx_pkts),
        .stat_rx_err_pkts   (stat_rx_err_pkts),
        .stat_rx_drop_words (stat_rx_drop_words)
`endif
    );

    always #5 clk_156m25 = ~clk_156m25;

    int n_vec = 0, n_err = 0, cyc = 0;
    int commits_owed = 0, ren_pct = 100, stall_pct = 0;
    int stall_left = 0, stall_trigger = 0, pops_seen = 0;
    int m_good = 0, m_bad = 0, m_drops = 0;
    bit commit_at_eop = 1'b0;
    logic avail_in_read = 1'b0;
    logic [71:0] stream[$];
    logic [71:0] fifo_q[$];
    logic [69:0] exp_q[$];
    int out_cycle[$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] ent(input logic sop, input logic eop, input logic err,
                                        input logic [2:0] mod, input logic [63:0] d);
        return {sop, eop, err, 2'b00, mod, d};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Expected output words from the framing rules: 0 = between packets, 1 = in packet, 2 = dropping.
    task automatic model_stream();
        int mode = 0;
        int cnt = 0;
        int i = 0;
        logic [71:0] e;
        while (i < stream.size()) begin
            e = stream[i];
            if (mode == 0) begin
                if (e[71]) begin
                    exp_q.push_back({1'b1, e[70], e[69], e[70] ? e[66:64] : 3'd0, e[63:0]});
                    cnt = 1;
                    i++;
                    if (e[70]) begin
                        if (e[69]) m_bad++; else m_good++;
                    end else mode = 1;
                end else mode = 2;
            end else if (mode == 1) begin
                if (e[71]) begin
                    exp_q.push_back({3'b011, 3'd0, 64'd0});
                    m_bad++;
                    mode = 0;
                end else begin
                    exp_q.push_back({1'b0, e[70], e[69], e[70] ? e[66:64] : 3'd0, e[63:0]});
                    cnt++;
                    i++;
                    if (e[70]) begin
                        if (e[69]) m_bad++; else m_good++;
                        mode = 0;
                    end else if (cnt == MAXW) begin
                        exp_q.push_back({3'b011, 3'd0, 64'd0});
                        m_bad++;
                        mode = 2;
                    end
                end
            end else begin
                if (e[71]) mode = 0;
                else begin
                    m_drops++;
                    i++;
                    if (e[70]) mode = 0;
                end
            end
        end
    endtask

    task automatic load(input bit defer_commit);
        model_stream();
        foreach (stream[k]) begin
            fifo_q.push_back(stream[k]);
            if (stream[k][70] && !defer_commit) commits_owed++;
        end
        stream.delete();
    endtask

    task automatic new_scenario();
        out_cycle.delete();
        pops_seen     = 0;
        stall_trigger = 0;
        avail_in_read = 1'b0;
    endtask

    task automatic step();
        logic [69:0] got;
        bit empty, pop;
        @(negedge clk_156m25);
        cyc++;
        if (pkt_rx.pkt_rx_val) begin
            got = {pkt_rx.pkt_rx_sop, pkt_rx.pkt_rx_eop, pkt_rx.pkt_rx_err,
                   pkt_rx.pkt_rx_mod, pkt_rx.pkt_rx_data};
            check("word_expected", 72'(exp_q.size() > 0), 72'd1);
            if (exp_q.size() > 0) begin
                check("word", 72'(got), 72'(exp_q.pop_front()));
                out_cycle.push_back(cyc);
                if (!pkt_rx.pkt_rx_sop) avail_in_read = avail_in_read | pkt_rx.pkt_rx_avail;
            end
        end
        pkt_rx.pkt_rx_ren = ($urandom_range(99) < ren_pct);
        if (stall_left > 0) begin
            stall_left--;
            empty = 1'b1;
        end else begin
            empty = ($urandom_range(99) < stall_pct);
        end
        if (fifo_q.size() == 0) empty = 1'b1;
        rxdfifo_rempty = empty;
        if (fifo_q.size() > 0) {rxdfifo_rstatus, rxdfifo_rdata} = fifo_q[0];
        rx_pkt_commit = (commits_owed > 0);
        if (commits_owed > 0) commits_owed--;
        #1;
        pop = rxdfifo_ren;
        if (empty) check("ren_when_empty", 72'(rxdfifo_ren), 72'd0);
        if (pop && commit_at_eop && fifo_q.size() > 0 && fifo_q[0][70]) begin
            rx_pkt_commit = 1'b1;
            commit_at_eop = 1'b0;
        end
        @(posedge clk_156m25);
        if (pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops_seen++;
            if (pops_seen == stall_trigger) stall_left = 5;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || commits_owed != 0 || commit_at_eop)
               && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 72'(exp_q.size() + fifo_q.size()), 72'd0);
        repeat (4) step();
        #2;
    endtask

    function automatic int gap_cycles();
        if (out_cycle.size() < 2) return -1;
        return out_cycle[out_cycle.size()-1] - out_cycle[0] - (out_cycle.size() - 1);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_val"},   72'(pkt_rx.pkt_rx_val),   72'd0);
        check({tag, "_avail"}, 72'(pkt_rx.pkt_rx_avail), 72'd0);
        check({tag, "_sop"},   72'(pkt_rx.pkt_rx_sop),   72'd0);
        check({tag, "_eop"},   72'(pkt_rx.pkt_rx_eop),   72'd0);
        check({tag, "_err"},   72'(pkt_rx.pkt_rx_err),   72'd0);
        check({tag, "_mod"},   72'(pkt_rx.pkt_rx_mod),   72'd0);
        check({tag, "_data"},  72'(pkt_rx.pkt_rx_data),  72'd0);
        check({tag, "_ren"},   72'(rxdfifo_ren),         72'd0);
    endtask

    task automatic gen_random(input int npkts);
        for (int p = 0; p < npkts; p++) begin
            int kind = $urandom_range(9);
            int len  = $urandom_range(1, 6);
            if (kind == 0) stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'($urandom), rnd64()));
            if (kind == 1) begin
                stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'($urandom), rnd64()));
                for (int m = 0; m < int'($urandom_range(2)); m++)
                    stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'($urandom), rnd64()));
            end
            for (int w = 0; w < len; w++)
                stream.push_back(ent(w == 0, w == len - 1, (w == len - 1) && ($urandom_range(3) == 0),
                                     3'($urandom), rnd64()));
        end
    endtask

    initial begin
        pkt_rx.pkt_rx_ren = 1'b0;
        repeat (3) @(posedge clk_156m25);
        #2;
        check_idle_outputs("reset");
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;

        // single packet, user holds off first so availability is visible
        new_scenario();
        ren_pct = 0;
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd2, 64'h1111_2222_3333_4444));
        stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'd7, 64'h5555_6666_7777_8888));
        stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd5, 64'h9999_AAAA_BBBB_CCCC));
        load(1'b0);
        repeat (4) step();
        #2;
        check("single_avail_before", 72'(pkt_rx.pkt_rx_avail), 72'd1);
        check("single_no_val", 72'(pkt_rx.pkt_rx_val), 72'd0);
        ren_pct = 100;
        drain(100);
        check("single_words", 72'(out_cycle.size()), 72'd3);
        check("single_avail_after", 72'(pkt_rx.pkt_rx_avail), 72'd0);

        // back-to-back 2-word packets
        new_scenario();
        for (int p = 0; p < 2; p++) begin
            stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
            stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd3, rnd64()));
        end
        load(1'b0);
        drain(100);
        check("b2b_words", 72'(out_cycle.size()), 72'd4);
        check("b2b_gap", 72'(gap_cycles()), 72'd1);
        check("b2b_avail_in_read", 72'(avail_in_read), 72'd0);

        // FIFO runs dry for 5 cycles after word 2 of 4
        new_scenario();
        stall_trigger = 2;
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd6, rnd64()));
        load(1'b0);
        drain(100);
        check("stall_words", 72'(out_cycle.size()), 72'd4);
        check("stall_gap", 72'(gap_cycles()), 72'd5);

        // truncated packet followed by an intact one
        new_scenario();
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd1, rnd64()));
        load(1'b0);
        drain(100);
        check("trunc_words", 72'(out_cycle.size()), 72'd6);

        // over-length: 6 words against a 4-word limit
        new_scenario();
        m_drops = 0;
`ifdef RX_DEQUEUE_STATS_EN
        begin
            logic [31:0] drop0 = stat_rx_drop_words;
`endif
        for (int w = 0; w < 6; w++)
            stream.push_back(ent(w == 0, w == 5, 1'b0, 3'd4, rnd64()));
        load(1'b0);
        drain(100);
        check("ovl_words", 72'(out_cycle.size()), 72'd5);
`ifdef RX_DEQUEUE_STATS_EN
            check("ovl_drop_stat", 72'(stat_rx_drop_words - drop0), 72'd2);
        end
`endif

        // leading garbage word before a packet
        new_scenario();
        stream.push_back(ent(1'b0, 1'b0, 1'b0, 3'd3, rnd64()));
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b1, 1'b1, 3'd2, rnd64()));
        load(1'b0);
        drain(100);
        check("garbage_words", 72'(out_cycle.size()), 72'd2);

        // second packet's commit lands on the cycle the first EOP is popped
        new_scenario();
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd0, rnd64()));
        load(1'b0);
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd7, rnd64()));
        load(1'b1);
        commit_at_eop = 1'b1;
        drain(100);
        check("coincide_words", 72'(out_cycle.size()), 72'd4);

        // randomized streams with random read throttling and FIFO starvation
        ren_pct   = 70;
        stall_pct = 20;
        for (int r = 0; r < 8; r++) begin
            new_scenario();
            gen_random(5);
            load(1'b0);
            drain(2000);
            check("rand_avail_in_read", 72'(avail_in_read), 72'd0);
        end
        ren_pct   = 100;
        stall_pct = 0;
`ifdef RX_DEQUEUE_STATS_EN
        check("stat_pkts", 72'(stat_rx_pkts), 72'(m_good));
        check("stat_err_pkts", 72'(stat_rx_err_pkts), 72'(m_bad));
`endif

        // reset in the middle of a packet
        new_scenario();
        for (int w = 0; w < 4; w++)
            stream.push_back(ent(w == 0, w == 3, 1'b0, 3'd1, rnd64()));
        load(1'b0);
        for (int n = 0; n < 50 && out_cycle.size() < 2; n++) step();
        check("reached_read", 72'(out_cycle.size() >= 2), 72'd1);
        #2;
        reset_156m25_n = 1'b0;
        @(posedge clk_156m25);
        #2;
        check_idle_outputs("midrst");
        fifo_q.delete();
        exp_q.delete();
        commits_owed   = 0;
        rxdfifo_rempty = 1'b1;
        m_good = 0;
        m_bad  = 0;
`ifdef RX_DEQUEUE_STATS_EN
        check("midrst_stat_pkts", 72'(stat_rx_pkts), 72'd0);
`endif
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;

        new_scenario();
        stream.push_back(ent(1'b1, 1'b0, 1'b0, 3'd0, rnd64()));
        stream.push_back(ent(1'b0, 1'b1, 1'b0, 3'd5, rnd64()));
        load(1'b0);
        drain(100);
        check("post_reset_words", 72'(out_cycle.size()), 72'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
